// File: rtl/int_addsub_pipe.sv
// Chunked add/subtract pipeline (ADD/SUB/ADC/SBB) with carry/overflow/zero/negative flags.
// Latency DATA_WIDTH/CHUNK_WIDTH register stages; the whole pipe freezes while out_valid & ~out_ready.
module int_addsub_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  carry_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  zero,
  output logic                  negative
);
  localparam int STAGES = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CW     = CHUNK_WIDTH;

  logic                  advance;
  logic [DATA_WIDTH-1:0] b_eff;
  logic                  c0;

  // Per-stage pipeline state; a_q/b_q hold the not-yet-consumed operand chunks, shifted down.
  logic                  vld_q [STAGES];
  logic [DATA_WIDTH-1:0] res_q [STAGES];
  logic                  cry_q [STAGES];
  logic                  zro_q [STAGES];
  logic [DATA_WIDTH-1:0] a_q   [STAGES-1];
  logic [DATA_WIDTH-1:0] b_q   [STAGES-1];
  logic                  ovf_q;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    b_eff = data_b;
    c0    = 1'b0;
    case (op)
      2'b00: begin b_eff = data_b;  c0 = 1'b0;      end
      2'b01: begin b_eff = ~data_b; c0 = 1'b1;      end
      2'b10: begin b_eff = data_b;  c0 = carry_in;  end
      2'b11: begin b_eff = ~data_b; c0 = ~carry_in; end
      default: begin b_eff = data_b; c0 = 1'b0;     end
    endcase
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    logic [CW-1:0]         a_c;
    logic [CW-1:0]         b_c;
    logic                  c_i;
    logic                  z_i;
    logic                  v_i;
    logic [DATA_WIDTH-1:0] r_i;
    logic [CW:0]           cs;

    if (s == 0) begin : g_first
      assign a_c = data_a[CW-1:0];
      assign b_c = b_eff[CW-1:0];
      assign c_i = c0;
      assign z_i = 1'b1;
      assign v_i = in_valid;
      assign r_i = '0;
    end else begin : g_next
      assign a_c = a_q[s-1][CW-1:0];
      assign b_c = b_q[s-1][CW-1:0];
      assign c_i = cry_q[s-1];
      assign z_i = zro_q[s-1];
      assign v_i = vld_q[s-1];
      assign r_i = res_q[s-1];
    end

    assign cs = {1'b0, a_c} + {1'b0, b_c} + {{CW{1'b0}}, c_i};

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q[s] <= 1'b0;
        res_q[s] <= '0;
        cry_q[s] <= 1'b0;
        zro_q[s] <= 1'b0;
      end else if (advance) begin
        vld_q[s] <= v_i;
        res_q[s] <= r_i | (DATA_WIDTH'(cs[CW-1:0]) << (CW * s));
        cry_q[s] <= cs[CW];
        zro_q[s] <= z_i & (cs[CW-1:0] == '0);
      end
    end

    if (s < STAGES - 1) begin : g_fwd
      if (s == 0) begin : g_src_in
        always_ff @(posedge clk) begin
          if (rst) begin
            a_q[s] <= '0;
            b_q[s] <= '0;
          end else if (advance) begin
            a_q[s] <= data_a >> CW;
            b_q[s] <= b_eff >> CW;
          end
        end
      end else begin : g_src_pipe
        always_ff @(posedge clk) begin
          if (rst) begin
            a_q[s] <= '0;
            b_q[s] <= '0;
          end else if (advance) begin
            a_q[s] <= a_q[s-1] >> CW;
            b_q[s] <= b_q[s-1] >> CW;
          end
        end
      end
    end else begin : g_last
      // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= (cs[CW-1] ^ a_c[CW-1] ^ b_c[CW-1]) ^ cs[CW];
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign carry_out = cry_q[STAGES-1];
  assign zero      = zro_q[STAGES-1];
  assign overflow  = ovf_q;
  assign negative  = sum[DATA_WIDTH-1];

endmodule

// File: tb/tb_int_addsub_pipe.sv
// Directed bench for int_addsub_pipe at default widths (4-stage pipe).
module tb_int_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        carry_out;
  logic        overflow;
  logic        zero;
  logic        negative;

  int checks = 0;
  int errors = 0;

  int_addsub_pipe #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data_a    (data_a),
    .data_b    (data_b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single beat: accepted at the first edge, result visible after the third edge after that.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic ci, input logic [31:0] es,
                       input logic eco, input logic eov, input logic ez, input logic en);
    op = o; data_a = a; data_b = b; carry_in = ci;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; data_a = $urandom; data_b = $urandom; carry_in = ~ci;
    repeat (2) @(posedge clk);
    #1 chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"},    32'(out_valid), 32'd1);
    chk({tag, "_sum"},      sum,            es);
    chk({tag, "_carry"},    32'(carry_out), 32'(eco));
    chk({tag, "_overflow"}, 32'(overflow),  32'(eov));
    chk({tag, "_zero"},     32'(zero),      32'(ez));
    chk({tag, "_negative"}, 32'(negative),  32'(en));
    @(posedge clk); #1;
    chk({tag, "_retired"},  32'(out_valid), 32'd0);
  endtask

  initial begin
    int tx_idx;
    int rx_idx;
    logic        stalled_prev;
    logic [31:0] sum_prev;

    // Reset with valid beats presented throughout.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; op = 2'b00;
    data_a = 32'h1234_5678; data_b = 32'h1111_1111; carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       sum,            32'd0);
    chk("rst_flags",     {28'd0, carry_out, overflow, zero, negative}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rst_no_ghost", 32'(out_valid), 32'd0);
    end

    // Directed arithmetic vectors.
    do_op("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op("sub_ovf",  2'b01, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op("sub_brw",  2'b01, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("adc_prop", 2'b10, 32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("sbb",      2'b11, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op("add_ovf",  2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);

    // Backpressure: 8 back-to-back ADDs, out_ready low in cycles 5..7.
    tx_idx = 0; rx_idx = 0; stalled_prev = 1'b0; sum_prev = '0;
    op = 2'b00; carry_in = 1'b0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      in_valid  = (tx_idx < 8);
      data_a    = 32'(tx_idx);
      data_b    = 32'h10;
      out_ready = !(cyc >= 5 && cyc <= 7);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (stalled_prev) begin
        chk("bp_stall_valid", 32'(out_valid), 32'd1);
        chk("bp_stall_sum",   sum,            sum_prev);
      end
      if (out_valid && out_ready) begin
        chk("bp_result", sum, 32'h10 + 32'(rx_idx));
        rx_idx++;
      end
      stalled_prev = out_valid && !out_ready;
      sum_prev     = sum;
      if (in_valid && in_ready) tx_idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_sent",     32'(tx_idx), 32'd8);
    chk("bp_received", 32'(rx_idx), 32'd8);

    // Reset with three beats in flight.
    out_ready = 1'b1; op = 2'b00; data_b = 32'h0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; data_a = 32'hA0 + 32'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_ghost", 32'(out_valid), 32'd0);
    end

    // Pipe is usable again after the mid-flight reset.
    do_op("post_rst", 2'b00, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
